// File: rtl/seq_bin2bcd.sv
// Sequential double-dabble binary-to-BCD converter, one bit per clock, with signed mode.
// Latency: done WIDTH cycles after the start edge; no backpressure, start is ignored while busy.
module seq_bin2bcd #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  signed_mode,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  negative,
    output logic                  overflow
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {IDLE, CONVERT} state_t;

    state_t                state;
    logic [WIDTH-1:0]      shift_q;
    logic [4*DIGITS-1:0]   digits_q;
    logic [CW-1:0]         count_q;
    logic                  sticky_q;
    logic                  neg_q;

    logic [4*DIGITS-1:0]   adj;
    logic [4*DIGITS-1:0]   digits_nxt;
    logic [WIDTH-1:0]      shift_nxt;
    logic                  carry;
    logic                  sign_in;
    logic [WIDTH-1:0]      mag_in;

    // Add-3 on every digit >= 5, then shift {digits, shift} left by one.
    // The bit leaving the top digit would belong to digit DIGITS: that is overflow.
    always_comb begin
        adj = '0;
        for (int i = 0; i < DIGITS; i++) begin
            adj[4*i +: 4] = (digits_q[4*i +: 4] >= 4'd5) ? digits_q[4*i +: 4] + 4'd3
                                                         : digits_q[4*i +: 4];
        end
        {carry, digits_nxt, shift_nxt} = {adj, shift_q, 1'b0};
    end

    assign sign_in = signed_mode & bin[WIDTH-1];
    assign mag_in  = sign_in ? (~bin + {{(WIDTH-1){1'b0}}, 1'b1}) : bin;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            shift_q  <= '0;
            digits_q <= '0;
            count_q  <= '0;
            sticky_q <= 1'b0;
            neg_q    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            bcd      <= '0;
            negative <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shift_q  <= mag_in;
                        digits_q <= '0;
                        sticky_q <= 1'b0;
                        neg_q    <= sign_in;
                        count_q  <= CW'(WIDTH);
                        busy     <= 1'b1;
                        state    <= CONVERT;
                    end
                end
                CONVERT: begin
                    shift_q  <= shift_nxt;
                    digits_q <= digits_nxt;
                    sticky_q <= sticky_q | carry;
                    count_q  <= count_q - CW'(1);
                    if (count_q == CW'(1)) begin
                        bcd      <= digits_nxt;
                        negative <= neg_q;
                        overflow <= sticky_q | carry;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_bin2bcd.sv
// Self-checking bench for seq_bin2bcd: three instances (W16/D5, W16/D4, W8/D3)
// compared against an arithmetic decimal reference model.
module tb_seq_bin2bcd;
    logic clk = 1'b0;
    logic reset = 1'b1;

    logic        s0 = 1'b0, m0 = 1'b0;
    logic [15:0] b0 = '0;
    logic        busy0, done0, neg0, ovf0;
    logic [19:0] bcd0;

    logic        s1 = 1'b0, m1 = 1'b0;
    logic [15:0] b1 = '0;
    logic        busy1, done1, neg1, ovf1;
    logic [15:0] bcd1;

    logic        s2 = 1'b0, m2 = 1'b0;
    logic [7:0]  b2 = '0;
    logic        busy2, done2, neg2, ovf2;
    logic [11:0] bcd2;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    seq_bin2bcd #(.WIDTH(16), .DIGITS(5)) dut0 (
        .clk(clk), .reset(reset), .start(s0), .signed_mode(m0), .bin(b0),
        .busy(busy0), .done(done0), .bcd(bcd0), .negative(neg0), .overflow(ovf0));
    seq_bin2bcd #(.WIDTH(16), .DIGITS(4)) dut1 (
        .clk(clk), .reset(reset), .start(s1), .signed_mode(m1), .bin(b1),
        .busy(busy1), .done(done1), .bcd(bcd1), .negative(neg1), .overflow(ovf1));
    seq_bin2bcd #(.WIDTH(8), .DIGITS(3)) dut2 (
        .clk(clk), .reset(reset), .start(s2), .signed_mode(m2), .bin(b2),
        .busy(busy2), .done(done2), .bcd(bcd2), .negative(neg2), .overflow(ovf2));

    // Reference: decimal digits of the magnitude, plain integer arithmetic.
    function automatic void model(input int w, input int d, input logic [15:0] b, input logic sm,
                                  output logic [19:0] e_bcd, output logic e_neg, output logic e_ovf);
        longint mag, lim, m;
        mag = longint'(b) & ((longint'(1) << w) - 1);
        e_neg = sm & mag[w-1];
        if (e_neg) mag = (longint'(1) << w) - mag;
        lim = 1;
        for (int i = 0; i < d; i++) lim = lim * 10;
        e_ovf = (mag >= lim);
        m = mag % lim;
        e_bcd = '0;
        for (int i = 0; i < d; i++) begin
            e_bcd[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
    endfunction

    // Launch one conversion on instance `which`; lat counts edges after the start edge.
    task automatic run_conv(input int which, input logic [15:0] b, input logic sm,
                            output logic [19:0] o_bcd, output logic o_neg, output logic o_ovf,
                            output int lat);
        logic got;
        got = 1'b0;
        @(negedge clk);
        case (which)
            0:       begin s0 = 1'b1; b0 = b;      m0 = sm; end
            1:       begin s1 = 1'b1; b1 = b;      m1 = sm; end
            default: begin s2 = 1'b1; b2 = b[7:0]; m2 = sm; end
        endcase
        @(posedge clk);
        #1;
        s0 = 1'b0; s1 = 1'b0; s2 = 1'b0;
        lat = 0;
        while (!got && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            case (which)
                0:       got = done0;
                1:       got = done1;
                default: got = done2;
            endcase
        end
        case (which)
            0:       begin o_bcd = bcd0;           o_neg = neg0; o_ovf = ovf0; end
            1:       begin o_bcd = {4'h0, bcd1};   o_neg = neg1; o_ovf = ovf1; end
            default: begin o_bcd = {8'h00, bcd2};  o_neg = neg2; o_ovf = ovf2; end
        endcase
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_total++;
        if ({busy0, done0, bcd0, neg0, ovf0} !== 24'h0)
            $display("FAIL reset_dut0 got %h want 0", {busy0, done0, bcd0, neg0, ovf0});
        else n_pass++;
        n_total++;
        if ({busy1, done1, bcd1, neg1, ovf1} !== 20'h0)
            $display("FAIL reset_dut1 got %h want 0", {busy1, done1, bcd1, neg1, ovf1});
        else n_pass++;
        n_total++;
        if ({busy2, done2, bcd2, neg2, ovf2} !== 16'h0)
            $display("FAIL reset_dut2 got %h want 0", {busy2, done2, bcd2, neg2, ovf2});
        else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_unsigned_max();
        logic [19:0] r; logic n, o; int lat;
        run_conv(0, 16'hFFFF, 1'b0, r, n, o, lat);
        n_total++;
        if (lat !== 16) $display("FAIL umax_latency got %0d want 16", lat); else n_pass++;
        n_total++;
        if ({r, n, o} !== {20'h65535, 1'b0, 1'b0})
            $display("FAIL umax_result got bcd=%h neg=%b ovf=%b want 65535/0/0", r, n, o);
        else n_pass++;
    endtask

    task automatic test_signed();
        logic [19:0] r; logic n, o; int lat;
        run_conv(0, 16'h8000, 1'b1, r, n, o, lat);
        n_total++;
        if ({r, n, o} !== {20'h32768, 1'b1, 1'b0})
            $display("FAIL signed_min got bcd=%h neg=%b ovf=%b want 32768/1/0", r, n, o);
        else n_pass++;
        run_conv(0, 16'hFFFF, 1'b1, r, n, o, lat);
        n_total++;
        if ({r, n, o} !== {20'h00001, 1'b1, 1'b0})
            $display("FAIL signed_m1 got bcd=%h neg=%b ovf=%b want 00001/1/0", r, n, o);
        else n_pass++;
    endtask

    task automatic test_overflow();
        logic [19:0] r; logic n, o; int lat;
        run_conv(1, 16'd12345, 1'b0, r, n, o, lat);
        n_total++;
        if ({r[15:0], n, o} !== {16'h2345, 1'b0, 1'b1})
            $display("FAIL ovf_12345 got bcd=%h neg=%b ovf=%b want 2345/0/1", r[15:0], n, o);
        else n_pass++;
        run_conv(1, 16'd9999, 1'b0, r, n, o, lat);
        n_total++;
        if ({r[15:0], n, o} !== {16'h9999, 1'b0, 1'b0})
            $display("FAIL ovf_9999 got bcd=%h neg=%b ovf=%b want 9999/0/0", r[15:0], n, o);
        else n_pass++;
    endtask

    task automatic test_zero();
        logic [19:0] r; logic n, o; int lat;
        for (int sm = 0; sm < 2; sm++) begin
            run_conv(0, 16'h0000, 1'(sm), r, n, o, lat);
            n_total++;
            if ({r, n, o} !== 22'h0)
                $display("FAIL zero_sm%0d got bcd=%h neg=%b ovf=%b want 0/0/0", sm, r, n, o);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [19:0] r, eb; logic n, o, en, eo; int lat; logic [15:0] v; logic sm;
        for (int k = 0; k < 60; k++) begin
            int which;
            which = k % 2;
            v  = 16'($urandom);
            sm = 1'($urandom);
            model(16, (which == 0) ? 5 : 4, v, sm, eb, en, eo);
            run_conv(which, v, sm, r, n, o, lat);
            n_total++;
            if ({r, n, o, lat} !== {eb, en, eo, 32'd16})
                $display("FAIL random dut%0d bin=%h sm=%b got bcd=%h neg=%b ovf=%b lat=%0d want %h/%b/%b/16",
                         which, v, sm, r, n, o, lat, eb, en, eo);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] bin_at[0:59];
        int ndone;
        logic [19:0] eb; logic en, eo;
        ndone = 0;
        @(negedge clk);
        s0 = 1'b1; m0 = 1'b1; b0 = 16'($urandom);
        for (int c = 0; c < 60; c++) begin
            @(posedge clk);
            bin_at[c] = b0;
            @(negedge clk);
            if (done0) begin
                ndone++;
                n_total++;
                if ((c % 17) != 16) begin
                    $display("FAIL b2b_timing done at edge %0d want edge 16 mod 17", c);
                end else begin
                    n_pass++;
                    model(16, 5, bin_at[c-16], 1'b1, eb, en, eo);
                    n_total++;
                    if ({bcd0, neg0, ovf0} !== {eb, en, eo})
                        $display("FAIL b2b_value edge %0d got bcd=%h neg=%b want bcd=%h neg=%b",
                                 c, bcd0, neg0, eb, en);
                    else n_pass++;
                end
            end
            b0 = 16'($urandom);
            s0 = (c + 1 < 40);
        end
        n_total++;
        if (ndone !== 3) $display("FAIL b2b_count got %0d dones want 3", ndone); else n_pass++;
    endtask

    task automatic test_reset_abort();
        logic [19:0] r; logic n, o; int lat; int seen;
        @(negedge clk);
        s0 = 1'b1; m0 = 1'b0; b0 = 16'd12345;
        @(posedge clk);
        #1 s0 = 1'b0;
        repeat (8) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        n_total++;
        if ({busy0, done0, bcd0, neg0, ovf0} !== 24'h0)
            $display("FAIL abort_clear got %h want 0", {busy0, done0, bcd0, neg0, ovf0});
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (done0) seen++;
        end
        n_total++;
        if (seen !== 0) $display("FAIL abort_no_done got %0d dones want 0", seen); else n_pass++;
        run_conv(0, 16'd4321, 1'b0, r, n, o, lat);
        n_total++;
        if ({r, n, o, lat} !== {20'h04321, 1'b0, 1'b0, 32'd16})
            $display("FAIL abort_next got bcd=%h neg=%b ovf=%b lat=%0d want 04321/0/0/16", r, n, o, lat);
        else n_pass++;
    endtask

    task automatic test_sweep_w8();
        logic [19:0] r, eb; logic n, o, en, eo; int lat;
        for (int sm = 0; sm < 2; sm++) begin
            for (int v = 0; v < 256; v++) begin
                model(8, 3, 16'(v), 1'(sm), eb, en, eo);
                run_conv(2, 16'(v), 1'(sm), r, n, o, lat);
                n_total++;
                if ({r, n, o, lat} !== {eb, en, 1'b0, 32'd8})
                    $display("FAIL sweep8 bin=%0d sm=%0d got bcd=%h neg=%b ovf=%b lat=%0d want %h/%b/0/8",
                             v, sm, r, n, o, lat, eb, en);
                else n_pass++;
            end
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_unsigned_max();
        test_signed();
        test_overflow();
        test_zero();
        test_random();
        test_back_to_back();
        test_reset_abort();
        test_sweep_w8();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
